pdi_pointwise_engine: RTL and testbench
=======================================

# pdi_pointwise_engine

Image-processing master for the PDI side of the three-channel image BRAM controller. On `start` it takes ownership of the BRAMs by asserting `pdi_active`, then sweeps pixel addresses 0..`pixel_count`-1. For each pixel it reads R/G/B in parallel, applies one point operation, and writes the result back in place. It sits between the top-level command logic, which issues `start`/`op`, and the BRAM controller's PDI port; it drives every PDI-side input of that controller.

## Interface
Parameters:
- ADDR_W, 17, pixel address width; matches BRAM depth of 131072.
- PIPE_LAT, 2, read-to-write distance in cycles (1 BRAM read + 1 compute register); fixed, not user-tunable.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  operation: 00 copy, 01 invert, 10 grayscale, 11 threshold; latched at start.
- threshold  in  8  threshold level for op 11; latched at start.
- pixel_count  in  17  number of pixels to process; latched at start.
- pdi_active  out  1  BRAM ownership request to controller.
- pdi_addr_read  out  17  read address to controller.
- pdi_addr_write  out  17  write address to controller.
- pdi_we  out  1  write strobe to all three BRAMs.
- red_data_in / green_data_in / blue_data_in  in  8 each  BRAM read data from controller.
- red_out / green_out / blue_out  out  8 each  write data to controller.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at completion.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `pixel_count`≠0 -> RUN.
  - `start` with `pixel_count`=0 -> DONE; no BRAM access.
- RUN: one read address issued per cycle from 0. After address `pixel_count`-1 is issued -> DRAIN.
- DRAIN: 2 cycles flushing the pipeline -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- Pipeline:
  - Stage 0 drives the read address.
  - Stage 1 receives BRAM data and registers the computed result together with the address delayed by 2.
  - `pdi_addr_write` = read address issued two cycles earlier.
- Operations:
  - copy: out = in.
  - invert: out = 255 − in, per channel.
  - grayscale: Y = (77·R + 150·G + 29·B) >> 8, computed in 16-bit unsigned, never overflows; written to all three channels.
  - threshold: Y as above; out = (Y ≥ threshold) ? 255 : 0 on all channels.
- Bus hygiene: the controller ORs PDI data with COM data. Therefore `red_out`/`green_out`/`blue_out` are 0 whenever `pdi_we`=0. `pdi_addr_read`/`pdi_addr_write` are 0 in IDLE/DONE.
- `start` while busy is ignored. `op`/`threshold`/`pixel_count` changes after start have no effect.
- Address counter never wraps; `pixel_count` ≤ 2^17−1 is representable, so a full 131072-pixel frame is not supported in one pass.

## Timing
- Reset values: all outputs 0, state IDLE. Applies the cycle after `rst` is sampled high, including mid-RUN/DRAIN. Aborted pixels are not written, and no `done` pulse is produced.
- Cycle 0: `start` sampled.
- Cycle 1: `pdi_active`=1, `busy`=1, `pdi_addr_read`=0.
- Cycle k (1..N): `pdi_addr_read`=k−1.
- Cycle k+2: `pdi_we`=1, `pdi_addr_write`=k−1, outputs = f(pixel k−1).
- Cycles N+1, N+2: DRAIN; `pdi_we` still 1.
- Cycle N+3: `done`=1; `pdi_active`=0, `busy`=0, `pdi_we`=0.
- Total latency for N pixels: N+3 cycles from start to done.
- `pdi_we` high for exactly N cycles, contiguous.
- Zero-count case: `done` at cycle 1; `pdi_active` never asserted.
- BRAM read latency is exactly 1 cycle; the engine does not stall.

## Configuration
- `PDI_THRESHOLD_EN` defined: op 11 performs threshold as specified.
- Not defined:
  - Comparator and `threshold` latch are removed.
  - op 11 behaves as copy.
  - The `threshold` port remains but is ignored.

## Test plan
- Copy, N=4, BRAM R=G=B = addr+10 -> writes addr 0..3 with 10..13 on cycles 3..6; `done` on cycle 7.
- Invert, N=1, R=0,G=128,B=255 -> write addr 0: 255,127,0; `pdi_we` high 1 cycle only.
- Grayscale, R=100,G=50,B=200 -> all channels 82. R=G=B=255 -> 255.
- Threshold with macro, threshold=82, same pixel -> 255. threshold=83 -> 0. Without macro -> pixel unchanged (100,50,200).
- `pixel_count`=0 -> `done` cycle 1, `pdi_active` and `pdi_we` stay 0.
- `rst` asserted at cycle 3 of N=8 run -> from next cycle all outputs 0, no further writes, no `done`. A new `start` then runs normally.

Source files
------------

// File: rtl/pdi_pointwise_engine.sv
// pdi_pointwise_engine: PDI-side image master. Sweeps pixel addresses
// 0..pixel_count-1, reads R/G/B, applies one point operation and writes the
// result back in place, with a fixed two-cycle read-to-write distance.
// Optional feature macro: PDI_THRESHOLD_EN (op 11 = threshold; otherwise copy).
module pdi_pointwise_engine #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [7:0]        threshold,
  input  logic [ADDR_W-1:0] pixel_count,
  output logic              pdi_active,
  output logic [ADDR_W-1:0] pdi_addr_read,
  output logic [ADDR_W-1:0] pdi_addr_write,
  output logic              pdi_we,
  input  logic [7:0]        red_data_in,
  input  logic [7:0]        green_data_in,
  input  logic [7:0]        blue_data_in,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DRAIN_W = 2;

  localparam logic [1:0] OP_COPY = 2'b00;
  localparam logic [1:0] OP_INV  = 2'b01;
  localparam logic [1:0] OP_GRAY = 2'b10;
  localparam logic [1:0] OP_THR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   count_q;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                d1_valid;
  logic [ADDR_W-1:0]   d1_addr;

  logic [15:0]         luma_sum;
  logic [7:0]          luma;
  logic [7:0]          res_r;
  logic [7:0]          res_g;
  logic [7:0]          res_b;

`ifdef PDI_THRESHOLD_EN
  logic [7:0]          thr_q;
`else
  logic                unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  // Point operation on the pixel returned by the BRAM this cycle
  always_comb begin
    luma_sum = 16'(16'd77  * 16'(red_data_in))
             + 16'(16'd150 * 16'(green_data_in))
             + 16'(16'd29  * 16'(blue_data_in));
    luma  = 8'(luma_sum >> 8);
    res_r = red_data_in;
    res_g = green_data_in;
    res_b = blue_data_in;
    case (op_q)
      OP_COPY: ;
      OP_INV: begin
        res_r = 8'hFF - red_data_in;
        res_g = 8'hFF - green_data_in;
        res_b = 8'hFF - blue_data_in;
      end
      OP_GRAY: begin
        res_r = luma;
        res_g = luma;
        res_b = luma;
      end
      OP_THR: begin
`ifdef PDI_THRESHOLD_EN
        res_r = (luma >= thr_q) ? 8'hFF : 8'h00;
        res_g = res_r;
        res_b = res_r;
`endif
      end
      default: ;
    endcase
  end

  // Control FSM, address generator and write-back pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_COPY;
      count_q        <= '0;
      drain_cnt      <= '0;
      d1_valid       <= 1'b0;
      d1_addr        <= '0;
      pdi_active     <= 1'b0;
      pdi_addr_read  <= '0;
      pdi_addr_write <= '0;
      pdi_we         <= 1'b0;
      red_out        <= '0;
      green_out      <= '0;
      blue_out       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef PDI_THRESHOLD_EN
      thr_q          <= '0;
`endif
    end else begin
      done <= 1'b0;

      // Stage 1: address travels alongside the returning read data
      d1_valid <= (state == S_RUN);
      d1_addr  <= pdi_addr_read;

      // Stage 2: registered write; data forced to 0 when not writing
      pdi_we         <= d1_valid;
      pdi_addr_write <= d1_valid ? d1_addr : '0;
      red_out        <= d1_valid ? res_r : 8'h00;
      green_out      <= d1_valid ? res_g : 8'h00;
      blue_out       <= d1_valid ? res_b : 8'h00;

      case (state)
        S_IDLE: begin
          pdi_addr_read <= '0;
          if (start) begin
            op_q    <= op;
            count_q <= pixel_count;
`ifdef PDI_THRESHOLD_EN
            thr_q   <= threshold;
`endif
            if (pixel_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_RUN;
              pdi_active <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pdi_addr_read == count_q - ADDR_W'(1)) begin
            state         <= S_DRAIN;
            pdi_addr_read <= '0;
            drain_cnt     <= '0;
          end else begin
            pdi_addr_read <= pdi_addr_read + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) begin
            state      <= S_DONE;
            done       <= 1'b1;
            pdi_active <= 1'b0;
            busy       <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdi_pointwise_engine.sv
// Scoreboard bench for pdi_pointwise_engine: directed vectors push expected
// writes into a queue; a negedge monitor pops and compares on every pdi_we.
module tb_pdi_pointwise_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  threshold;
  logic [16:0] pixel_count;
  logic        pdi_active;
  logic [16:0] pdi_addr_read;
  logic [16:0] pdi_addr_write;
  logic        pdi_we;
  logic [7:0]  red_data_in, green_data_in, blue_data_in;
  logic [7:0]  red_out, green_out, blue_out;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  e;
  wr_t  act;
  logic [7:0] mem_r[16];
  logic [7:0] mem_g[16];
  logic [7:0] mem_b[16];
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  pdi_pointwise_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .threshold(threshold),
    .pixel_count(pixel_count), .pdi_active(pdi_active),
    .pdi_addr_read(pdi_addr_read), .pdi_addr_write(pdi_addr_write),
    .pdi_we(pdi_we), .red_data_in(red_data_in), .green_data_in(green_data_in),
    .blue_data_in(blue_data_in), .red_out(red_out), .green_out(green_out),
    .blue_out(blue_out), .busy(busy), .done(done)
  );

  // BRAM model with one-cycle read latency
  always @(posedge clk) begin
    red_data_in   <= mem_r[4'(pdi_addr_read)];
    green_data_in <= mem_g[4'(pdi_addr_read)];
    blue_data_in  <= mem_b[4'(pdi_addr_read)];
  end

  // Monitor: compare every write against the scoreboard, check bus hygiene
  always @(negedge clk) begin
    if (mon_en) begin
      if (pdi_we) begin
        we_count++;
        checks++;
        act = '{a: pdi_addr_write, r: red_out, g: green_out, b: blue_out};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual addr=%0d rgb=%0d,%0d,%0d required none",
                   pdi_addr_write, red_out, green_out, blue_out);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL write actual addr=%0d rgb=%0d,%0d,%0d required addr=%0d rgb=%0d,%0d,%0d",
                     act.a, act.r, act.g, act.b, e.a, e.r, e.g, e.b);
          end
        end
      end else begin
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h0) begin
          failures++;
          $display("FAIL bus_hygiene actual rgb=%0d,%0d,%0d required 0,0,0",
                   red_out, green_out, blue_out);
        end
      end
    end
  end

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic push(input int a, input int r, input int g, input int b);
    exp_q.push_back('{a: 17'(a), r: 8'(r), g: 8'(g), b: 8'(b)});
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      mem_r[i] = 8'(i + 10);
      mem_g[i] = 8'(i + 10);
      mem_b[i] = 8'(i + 10);
    end
  endtask

  // Start one job, scramble latched inputs afterwards, time done and writes
  task automatic run_job(input string name, input logic [1:0] o, input logic [7:0] t,
                         input int n);
    int c;
    bit saw_active;
    we_count = 0;
    @(negedge clk);
    op = o; threshold = t; pixel_count = 17'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; threshold = ~t; pixel_count = 17'd5;
    c = 1;
    saw_active = pdi_active;
    if (n != 0) begin
      chk({name, "_active_c1"}, int'(pdi_active), 1);
      chk({name, "_busy_c1"}, int'(busy), 1);
      chk({name, "_addr_read_c1"}, int'(pdi_addr_read), 0);
    end
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      if (pdi_active) saw_active = 1'b1;
    end
    chk({name, "_done_cycle"}, c, (n == 0) ? 1 : n + 3);
    if (n == 0) chk({name, "_active_never"}, int'(saw_active), 0);
    else chk({name, "_active_at_done"}, int'(pdi_active), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, int'(done), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_we_cycles"}, we_count, n);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int saw_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; threshold = 8'd0; pixel_count = '0;
    fill_ramp();
    repeat (2) @(negedge clk);
    chk("rst_outputs",
        int'({pdi_active, pdi_we, busy, done}) | int'(pdi_addr_read) | int'(pdi_addr_write)
        | int'({red_out, green_out, blue_out}), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // copy N=4 over a ramp
    for (int i = 0; i < 4; i++) push(i, i + 10, i + 10, i + 10);
    run_job("copy4", 2'b00, 8'd0, 4);

    // invert N=1
    mem_r[0] = 8'd0; mem_g[0] = 8'd128; mem_b[0] = 8'd255;
    push(0, 255, 127, 0);
    run_job("invert1", 2'b01, 8'd0, 1);

    // grayscale: (100,50,200) -> 82, white stays 255
    mem_r[0] = 8'd100; mem_g[0] = 8'd50;  mem_b[0] = 8'd200;
    mem_r[1] = 8'd255; mem_g[1] = 8'd255; mem_b[1] = 8'd255;
    push(0, 82, 82, 82);
    push(1, 255, 255, 255);
    run_job("gray2", 2'b10, 8'd0, 2);

    // threshold at the luma boundary
`ifdef PDI_THRESHOLD_EN
    push(0, 255, 255, 255);
    run_job("thr82", 2'b11, 8'd82, 1);
    push(0, 0, 0, 0);
    run_job("thr83", 2'b11, 8'd83, 1);
`else
    push(0, 100, 50, 200);
    run_job("thr82", 2'b11, 8'd82, 1);
    push(0, 100, 50, 200);
    run_job("thr83", 2'b11, 8'd83, 1);
`endif

    // zero pixel count
    run_job("zero", 2'b00, 8'd0, 0);

    // reset at cycle 3 of an N=8 run: only pixel 0 reaches the bus
    fill_ramp();
    we_count = 0;
    push(0, 10, 10, 10);
    @(negedge clk);
    op = 2'b00; pixel_count = 17'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs",
        int'({pdi_active, pdi_we, busy, done}) | int'(pdi_addr_read) | int'(pdi_addr_write)
        | int'({red_out, green_out, blue_out}), 0);
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || pdi_active) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_we_cycles", we_count, 1);
    chk("abort_queue_left", exp_q.size(), 0);
    exp_q.delete();

    // normal run after the abort
    for (int i = 0; i < 3; i++) push(i, i + 10, i + 10, i + 10);
    run_job("copy3", 2'b00, 8'd0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
